// File: rtl/stack_master_pkg.sv
// Shared definitions for the stack master: command codes, FSM states and
// the fixed length of the post-strobe hold phase.
package stack_master_pkg;

    typedef enum logic [1:0] {
        OP_STATUS = 2'b00,
        OP_PUSH   = 2'b01,
        OP_POP    = 2'b10,
        OP_CLEAR  = 2'b11
    } cmdOp_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_e;

    localparam int HOLD_CYC = 2;
    localparam int CNT_W    = 16;

endpackage

// File: rtl/stack_master_sync2.sv
// Two-flop synchronizer for one asynchronous stack flag.
module sync2 (
    input  logic Clk,
    input  logic Reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/stack_master.sv
// Command-driven master for an external stack with a shared tri-state data
// bus, timed push/pop/reset strobes and synchronized status flags.
module stack_master
    import stack_master_pkg::*;
#(
    parameter int DW        = 4,
    parameter int PULSE_CYC = 2,
    parameter int SETUP_CYC = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CmdValid,
    output logic          CmdReady,
    input  logic [1:0]    CmdOp,
    input  logic [DW-1:0] CmdData,
    output logic          RspValid,
    output logic [DW-1:0] RspData,
    output logic          RspErr,
    inout  wire  [DW-1:0] StkData,
    output logic          StkPush,
    output logic          StkPop,
    output logic          StkReset,
    input  logic          StkFull,
    input  logic          StkEmpty,
    input  logic          StkErr
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmdOp_e           op_q, op_d;
    logic [DW-1:0]    data_q, data_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             stkPush_q, stkPush_d;
    logic             stkPop_q, stkPop_d;
    logic             stkReset_q, stkReset_d;
    logic             drive_q, drive_d;

    logic fullSync;
    logic emptySync;
    logic errSync;

    sync2 uSyncFull (
        .Clk   (Clk),
        .Reset (Reset),
        .d_i   (StkFull),
        .q_o   (fullSync)
    );

    sync2 uSyncEmpty (
        .Clk   (Clk),
        .Reset (Reset),
        .d_i   (StkEmpty),
        .q_o   (emptySync)
    );

    sync2 uSyncErr (
        .Clk   (Clk),
        .Reset (Reset),
        .d_i   (StkErr),
        .q_o   (errSync)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_STATUS;
            data_q     <= '0;
            rdata_q    <= '0;
            stkPush_q  <= 1'b0;
            stkPop_q   <= 1'b0;
            stkReset_q <= 1'b0;
            drive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            stkPush_q  <= stkPush_d;
            stkPop_q   <= stkPop_d;
            stkReset_q <= stkReset_d;
            drive_q    <= drive_d;
        end
    end

    // Strobes and bus enable are decoded from the next state so they can be
    // registered and leave the block straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (CmdValid) begin
                    op_d   = cmdOp_e'(CmdOp);
                    data_d = CmdData;
                    case (cmdOp_e'(CmdOp))
                        OP_STATUS: state_d = RESP;
                        OP_PUSH:   state_d = SETUP;
                        default:   state_d = STROBE;
                    endcase
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STROBE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    if (op_q == OP_POP) begin
                        rdata_d = StkData;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stkPush_d  = (state_d == STROBE) && (op_d == OP_PUSH);
        stkPop_d   = (state_d == STROBE) && (op_d == OP_POP);
        stkReset_d = (state_d == STROBE) && (op_d == OP_CLEAR);
        drive_d    = (op_d == OP_PUSH) && (state_d inside {SETUP, STROBE, HOLD});
    end

    always_comb begin
        RspData = '0;
        if (state_q == RESP) begin
            case (op_q)
                OP_STATUS: begin
                    RspData[DW-1] = fullSync;
                    RspData[DW-2] = emptySync;
                    RspData[DW-3] = errSync;
                end
                OP_POP:  RspData = rdata_q;
                default: RspData = '0;
            endcase
        end
    end

    assign CmdReady = (state_q == IDLE);
    assign RspValid = (state_q == RESP);
    assign RspErr   = (state_q == RESP) && ((op_q == OP_PUSH) || (op_q == OP_POP)) && errSync;
    assign StkPush  = stkPush_q;
    assign StkPop   = stkPop_q;
    assign StkReset = stkReset_q;
    assign StkData  = drive_q ? data_q : {DW{1'bz}};

endmodule

// File: tb/tb_stack_master.sv
// Bench for stack_master: an eight-deep stack device on the tri-state bus plus
// a queue-based reference of the expected responses and strobe timing.
module tb_stack_master;

    localparam int DW    = 4;
    localparam int PULSE = 2;
    localparam int SETUP = 1;
    localparam int HOLDC = 2;
    localparam int DEPTH = 8;

    localparam logic [1:0] OP_ST = 2'b00;
    localparam logic [1:0] OP_PU = 2'b01;
    localparam logic [1:0] OP_PO = 2'b10;
    localparam logic [1:0] OP_CL = 2'b11;

    logic          Clk      = 1'b0;
    logic          Reset    = 1'b0;
    logic          CmdValid = 1'b0;
    logic [1:0]    CmdOp    = 2'b00;
    logic [DW-1:0] CmdData  = '0;
    logic          CmdReady;
    logic          RspValid;
    logic [DW-1:0] RspData;
    logic          RspErr;
    tri0  [DW-1:0] StkData;
    logic          StkPush;
    logic          StkPop;
    logic          StkReset;
    logic          StkFull;
    logic          StkEmpty;
    logic          StkErr;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    stack_master #(
        .DW        (DW),
        .PULSE_CYC (PULSE),
        .SETUP_CYC (SETUP)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdOp    (CmdOp),
        .CmdData  (CmdData),
        .RspValid (RspValid),
        .RspData  (RspData),
        .RspErr   (RspErr),
        .StkData  (StkData),
        .StkPush  (StkPush),
        .StkPop   (StkPop),
        .StkReset (StkReset),
        .StkFull  (StkFull),
        .StkEmpty (StkEmpty),
        .StkErr   (StkErr)
    );

    // Stack device: reacts to strobe rising edges, drives the bus while popping.
    logic [DW-1:0] mem [DEPTH];
    int            mCnt     = 0;
    logic          mErr     = 1'b0;
    logic          popDrive = 1'b0;
    logic [DW-1:0] popVal   = '0;
    logic          prevPush = 1'b0;
    logic          prevPop  = 1'b0;
    logic          prevRst  = 1'b0;

    assign StkData  = popDrive ? popVal : {DW{1'bz}};
    assign StkFull  = (mCnt == DEPTH);
    assign StkEmpty = (mCnt == 0);
    assign StkErr   = mErr;

    always @(StkPush or StkPop or StkReset) begin
        if (StkReset && !prevRst) begin
            mCnt = 0;
            mErr = 1'b0;
        end
        if (StkPush && !prevPush) begin
            if (mCnt == DEPTH) mErr = 1'b1;
            else begin
                mem[mCnt] = StkData;
                mCnt++;
            end
        end
        if (StkPop && !prevPop) begin
            if (mCnt == 0) mErr = 1'b1;
            else begin
                mCnt--;
                popVal   = mem[mCnt];
                popDrive = 1'b1;
            end
        end else if (!StkPop) begin
            popDrive = 1'b0;
        end
        prevRst  = StkReset;
        prevPush = StkPush;
        prevPop  = StkPop;
    end

    // Reference of what the stack should hold and whether its error is set.
    logic [DW-1:0] refStk[$];
    bit            refErr = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            checkOutput("oneStrobe", 32'($onehot0({StkPush, StkPop, StkReset})), 32'd1);
            if (StkPop) checkOutput("popBusFree", 32'(StkData), 32'(popDrive ? popVal : '0));
        end
    end

    task automatic refPush(input logic [DW-1:0] d);
        if (refStk.size() == DEPTH) refErr = 1'b1;
        else refStk.push_back(d);
    endtask

    // Issues one command at a negedge and checks every cycle until its response.
    task automatic applyStimulus(input logic [1:0] op, input logic [DW-1:0] d, input bit keepValid,
                                 output logic [DW-1:0] rdata, output logic rerr);
        logic [DW-1:0] expData;
        logic [DW-1:0] expBus;
        logic [DW-1:0] busK;
        bit            expErr;
        int            lat;
        int            w;
        string         nm;
        expData = '0;
        expBus  = '0;
        expErr  = 1'b0;
        lat     = 1;
        rdata   = '0;
        rerr    = 1'b0;
        case (op)
            OP_ST: begin
                nm = "status";
                expData[DW-1] = (refStk.size() == DEPTH);
                expData[DW-2] = (refStk.size() == 0);
                expData[DW-3] = refErr;
                lat = 1;
            end
            OP_PU: begin
                nm = "push";
                refPush(d);
                expErr = refErr;
                lat = SETUP + PULSE + HOLDC + 1;
            end
            OP_PO: begin
                nm = "pop";
                if (refStk.size() == 0) refErr = 1'b1;
                else expData = refStk.pop_back();
                expBus = expData;
                expErr = refErr;
                lat = PULSE + HOLDC + 1;
            end
            default: begin
                nm = "clear";
                refStk.delete();
                refErr = 1'b0;
                lat = PULSE + HOLDC + 1;
            end
        endcase
        CmdValid = 1'b1;
        CmdOp    = op;
        CmdData  = d;
        w = 0;
        while (CmdReady !== 1'b1 && w < 50) begin
            @(negedge Clk);
            w++;
        end
        if (w >= 50) begin
            checkOutput({nm, ".acceptTimeout"}, 32'(CmdReady), 32'd1);
            CmdValid = 1'b0;
            return;
        end
        @(posedge Clk);
        @(negedge Clk);
        CmdValid = keepValid;
        CmdOp    = 2'($urandom);
        CmdData  = DW'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge Clk);
            checkOutput($sformatf("%s.rspValid@T+%0d", nm, k), 32'(RspValid), 32'(k == lat));
            checkOutput($sformatf("%s.cmdReady@T+%0d", nm, k), 32'(CmdReady), 32'd0);
            checkOutput($sformatf("%s.stkPush@T+%0d", nm, k), 32'(StkPush),
                        32'(op == OP_PU && k > SETUP && k <= SETUP + PULSE));
            checkOutput($sformatf("%s.stkPop@T+%0d", nm, k), 32'(StkPop), 32'(op == OP_PO && k <= PULSE));
            checkOutput($sformatf("%s.stkReset@T+%0d", nm, k), 32'(StkReset), 32'(op == OP_CL && k <= PULSE));
            busK = '0;
            if (op == OP_PU && k < lat) busK = d;
            if (op == OP_PO && k <= PULSE) busK = expBus;
            checkOutput($sformatf("%s.bus@T+%0d", nm, k), 32'(StkData), 32'(busK));
        end
        rdata = RspData;
        rerr  = RspErr;
        checkOutput({nm, ".rspData"}, 32'(RspData), 32'(expData));
        checkOutput({nm, ".rspErr"}, 32'(RspErr), 32'(expErr));
    endtask

    task automatic applyResetAbort(input logic [DW-1:0] d);
        int w;
        CmdValid = 1'b1;
        CmdOp    = OP_PU;
        CmdData  = d;
        w = 0;
        while (CmdReady !== 1'b1 && w < 50) begin
            @(negedge Clk);
            w++;
        end
        @(posedge Clk);
        @(negedge Clk);
        CmdValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("abort.pushBefore", 32'(StkPush), 32'd1);
        checkOutput("abort.busBefore", 32'(StkData), 32'(d));
        refPush(d);
        Reset = 1'b1;
        #1;
        checkOutput("abort.pushLow", 32'(StkPush), 32'd0);
        checkOutput("abort.busZ", 32'(StkData), 32'd0);
        checkOutput("abort.cmdReady", 32'(CmdReady), 32'd1);
        checkOutput("abort.rspValid", 32'(RspValid), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            checkOutput($sformatf("abort.noRsp%0d", k), 32'(RspValid), 32'd0);
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          re;
        int            r;
        $display("[TB] stack_master bench start");
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checkOutput("reset.cmdReady", 32'(CmdReady), 32'd1);
        checkOutput("reset.rspValid", 32'(RspValid), 32'd0);
        checkOutput("reset.rspErr", 32'(RspErr), 32'd0);
        checkOutput("reset.rspData", 32'(RspData), 32'd0);
        checkOutput("reset.strobes", 32'({StkPush, StkPop, StkReset}), 32'd0);
        checkOutput("reset.bus", 32'(StkData), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        applyStimulus(OP_CL, 4'h5, 1'b0, rd, re);
        applyStimulus(OP_PU, 4'hA, 1'b0, rd, re);
        checkOutput("pushA.err", 32'(re), 32'd0);

        applyStimulus(OP_PU, 4'h3, 1'b0, rd, re);
        applyStimulus(OP_PO, 4'hE, 1'b0, rd, re);
        checkOutput("pop3.data", 32'(rd), 32'h3);

        applyStimulus(OP_CL, 4'h7, 1'b0, rd, re);
        for (int i = 1; i <= 9; i++) applyStimulus(OP_PU, DW'(i), 1'b0, rd, re);
        checkOutput("push9.err", 32'(re), 32'd1);
        applyStimulus(OP_ST, 4'h6, 1'b0, rd, re);
        checkOutput("full.status", 32'(rd), 32'b1010);

        applyStimulus(OP_CL, 4'h9, 1'b0, rd, re);
        applyStimulus(OP_PO, 4'hF, 1'b0, rd, re);
        checkOutput("popEmpty.err", 32'(re), 32'd1);

        applyStimulus(OP_CL, 4'h2, 1'b0, rd, re);
        applyResetAbort(4'hC);
        applyStimulus(OP_ST, 4'hB, 1'b0, rd, re);

        applyStimulus(OP_CL, 4'h1, 1'b1, rd, re);
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3 || r == 9) applyStimulus(OP_PU, DW'($urandom), 1'b1, rd, re);
            else if (r <= 6)      applyStimulus(OP_PO, DW'($urandom), 1'b1, rd, re);
            else if (r == 7)      applyStimulus(OP_ST, DW'($urandom), 1'b1, rd, re);
            else                  applyStimulus(OP_CL, DW'($urandom), 1'b1, rd, re);
        end
        CmdValid = 1'b0;
        repeat (2) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_master.md
STACK_MASTER -- requirements
Module: stack_master

Interface
REQ-001 SHALL have parameter DW, default 4, data width of the stack bus; legal values DW >= 3.
REQ-002 SHALL have parameter PULSE_CYC, default 2, number of Clk cycles each strobe is held high; legal values PULSE_CYC >= 1.
REQ-003 SHALL have parameter SETUP_CYC, default 1, number of Clk cycles data is driven before a Push strobe rises; legal values SETUP_CYC >= 1.
REQ-004 Clk  in  1  system clock; all state changes on the rising edge.
REQ-005 Reset  in  1  reset, asynchronous, active-high.
REQ-006 CmdValid  in  1  command request.
REQ-007 CmdReady  out  1  command accept; a command is taken when CmdValid and CmdReady are high at a Clk edge.
REQ-008 CmdOp  in  2  command code: 00 STATUS, 01 PUSH, 10 POP, 11 CLEAR.
REQ-009 CmdData  in  DW  push data.
REQ-010 RspValid  out  1  one-cycle response pulse; there is no backpressure.
REQ-011 RspData  out  DW  popped data, or status word.
REQ-012 RspErr  out  1  command error flag, valid while RspValid is high.
REQ-013 StkData  inout  DW  bidirectional stack data bus; high-Z when not driving.
REQ-014 StkPush, StkPop, StkReset  out  1 each  strobes to the stack.
REQ-015 StkFull, StkEmpty, StkErr  in  1 each  stack flags; asynchronous to Clk.

Function
REQ-016 SHALL use an FSM with states IDLE, SETUP, STROBE, HOLD, RESP; CmdReady SHALL be high only in IDLE.
REQ-017 STATUS SHALL go IDLE->RESP: accepted at edge T, RspValid high in cycle T+1.
- RspData[DW-1] = Full, RspData[DW-2] = Empty, RspData[DW-3] = Err, using the synchronized flags.
- All other RspData bits = 0; RspErr = 0.
REQ-018 PUSH accepted at T SHALL run this sequence (defaults: strobe T+2..T+3, RspValid T+6):
- SETUP for SETUP_CYC cycles: CmdData, registered at T, driven on StkData.
- STROBE for PULSE_CYC cycles: StkPush high, data still driven.
- HOLD for 2 cycles: StkPush low, data still driven.
- RESP for 1 cycle: bus released to high-Z.
REQ-019 POP accepted at T SHALL skip SETUP and run STROBE (StkPop high, PULSE_CYC cycles), HOLD (2 cycles), RESP (defaults: RspValid T+5).
- StkData SHALL be sampled into RspData at the Clk edge ending the last STROBE cycle.
REQ-020 CLEAR SHALL run STROBE (StkReset high, PULSE_CYC cycles), HOLD (2 cycles), RESP.
- In RESP: RspData = 0, RspErr = 0.
REQ-021 For PUSH and POP, RspErr SHALL equal the synchronized StkErr in the RESP cycle.
REQ-022 At most one of StkPush, StkPop, StkReset SHALL be high in any cycle.
REQ-023 StkData SHALL never be driven while StkPop is high.
- The bus SHALL be released at least 1 cycle before any StkPop rise; RESP plus IDLE guarantees this turnaround.
REQ-024 StkFull, StkEmpty and StkErr SHALL each pass through a 2-flop synchronizer before any use.
REQ-025 Strobes SHALL come directly from flops: glitch-free, clean edges.
REQ-026 CmdOp and CmdData SHALL be registered at accept; later input changes SHALL NOT affect a command in flight.

Reset
REQ-027 While Reset is high, the block SHALL hold:
- FSM = IDLE; CmdReady = 1.
- RspValid, RspErr, RspData, StkPush, StkPop, StkReset and synchronizer flops = 0.
- StkData high-Z.
REQ-028 Reset asserted mid-operation SHALL abort immediately (asynchronously); the aborted command SHALL give no response.
- The first command accepted after release SHALL execute normally.

Structure
REQ-029 Package stack_master_pkg SHALL hold the CmdOp encodings, the FSM state enum, and the HOLD length constant (2).
REQ-030 The flag synchronizer SHALL be a sub-module named sync2, instantiated three times.

Verification
REQ-031 The bench SHALL cover these directed scenarios (bus model plus stack model attached):
- CLEAR, then PUSH 4'hA: StkPush high in cycles T+2..T+3 with StkData = 4'hA throughout; RspValid at T+6, RspErr = 0.
- PUSH 4'h3, then POP: RspData = 4'h3 at T+5; StkData high-Z during the StkPop pulse.
- 9 PUSHes of 4'h1..4'h9 after CLEAR: ninth response RspErr = 1; STATUS then returns 4'b1010 (Full = 1, Empty = 0, Err = 1, bit0 = 0).
- POP on an empty stack after CLEAR (model's Err rises): RspErr = 1.
- Reset asserted at T+3 of a PUSH: StkPush low and StkData high-Z in the same cycle; no RspValid; a following STATUS is accepted.
- CmdValid held high with back-to-back ops: CmdReady low while busy; no cycle with two strobes high, or with StkPop high while StkData is driven (assertion).
